// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the fetch front end.
//   RISC_ADDR_W / RISC_DATA_W : default PC and instruction widths
//   ifb_state_t               : fetch buffer FSM state {FETCH, DRAIN}
//   fetch_pkt_t               : {pc, instr} pair handed to decode
package risc_pkg;

  localparam int RISC_ADDR_W = 32;
  localparam int RISC_DATA_W = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifb_state_t;

  typedef struct packed {
    logic [RISC_ADDR_W-1:0] pc;
    logic [RISC_DATA_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifetch_buffer_if.sv
// ifetch_buffer_if: bundles the PC, instruction-memory and decode handshakes
// of the fetch buffer.
//   slave  modport : the fetch buffer side
//   master modport : the environment side (PC, memory, decode)
interface ifetch_buffer_if
  import risc_pkg::*;
#(
  parameter int ADDR_W = RISC_ADDR_W,
  parameter int DATA_W = RISC_DATA_W
) ();

  logic              flush;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_hold;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  modport slave (
    input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output pc_hold, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

  modport master (
    output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  pc_hold, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

endinterface

// File: rtl/ifb_fifo.sv
// ifb_fifo: synchronous FIFO, DEPTH a power of two.
//   clk, reset : clock, asynchronous active-high reset of pointers/count
//   clr        : synchronous empty (wins over push)
//   push/wdata : write when not full
//   pop/rdata  : rdata shows the head; pop advances when not empty
//   full, empty, count : occupancy
module ifb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: fetch stage between the PC and decode.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ifetch_buffer_if.slave
//     pc_in/pc_hold/flush          : PC interface and redirect
//     imem_req_*/imem_rsp_*        : in-order instruction memory
//     dec_valid/dec_instr/dec_pc/dec_ready : decode handshake
// A tag FIFO remembers the PC of every accepted request (its count is the
// number of outstanding requests); responses are paired with their tag and
// queued for decode. After a flush with requests still in flight the FSM
// sits in DRAIN and throws those responses away.
// Build option: IFB_BYPASS_EN lets a response reach decode in the same cycle
// when the instruction queue is empty.
module ifetch_buffer
  import risc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RISC_ADDR_W,
  parameter int DATA_W = RISC_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PKT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ifb_state_t        state_q, state_d;
  logic              req_valid, accept, rsp_keep, q_clr;
  logic              tag_push, tag_pop, tag_full, tag_empty;
  logic [ADDR_W-1:0] tag_head;
  logic [CNT_W-1:0]  outstanding, out_after;
  logic              q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [PKT_W-1:0]  q_wdata, q_rdata;

  // A response with nothing outstanding is a tag FIFO underflow.
  assign tag_pop   = bus.imem_rsp_valid & ~tag_empty;
  assign out_after = outstanding - CNT_W'(tag_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (bus.flush && out_after != '0) state_d = DRAIN;
      // Leaving on the zero check first keeps a late flush from stranding DRAIN.
      DRAIN:   if (out_after == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    rsp_keep  = 1'b0;
    q_clr     = bus.flush;
    case (state_q)
      FETCH: begin
        // Reserve a queue slot for every request so responses never overflow.
        req_valid = ~bus.flush & ~reset & ((q_count + outstanding) < DEPTH_C);
        rsp_keep  = tag_pop & ~bus.flush;
      end
      default: ;
    endcase
  end

  assign accept             = req_valid & bus.imem_req_ready;
  assign tag_push           = accept & ~tag_full;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_hold        = ~accept;

  assign q_wdata = {tag_head, bus.imem_rsp_data};
  assign q_pop   = ~q_empty & bus.dec_ready;

`ifdef IFB_BYPASS_EN
  logic byp_valid;
  assign byp_valid     = rsp_keep & q_empty;
  assign q_push        = rsp_keep & ~(byp_valid & bus.dec_ready) & ~q_full;
  assign bus.dec_valid = ~q_empty | byp_valid;
  assign bus.dec_pc    = ~q_empty ? q_rdata[PKT_W-1:DATA_W]
                                  : (byp_valid ? tag_head : '0);
  assign bus.dec_instr = ~q_empty ? q_rdata[DATA_W-1:0]
                                  : (byp_valid ? bus.imem_rsp_data : '0);
`else
  assign q_push        = rsp_keep & ~q_full;
  assign bus.dec_valid = ~q_empty;
  // Outputs read zero whenever nothing valid is presented.
  assign bus.dec_pc    = q_empty ? '0 : q_rdata[PKT_W-1:DATA_W];
  assign bus.dec_instr = q_empty ? '0 : q_rdata[DATA_W-1:0];
`endif

  ifb_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .push  (tag_push),
    .pop   (tag_pop),
    .wdata (bus.pc_in),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  ifb_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .clr   (q_clr),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  a_rsp_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) bus.imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;
  import risc_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_buffer_if #(.ADDR_W(RISC_ADDR_W), .DATA_W(RISC_DATA_W)) bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .ADDR_W(RISC_ADDR_W), .DATA_W(RISC_DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          lat_exp;
  int          c0;
  logic [31:0] pc_model, target, held;
  mem_req_t    mem_q[$];
  fetch_pkt_t  exp_q[$];
  int          acc_cnt, dec_cnt, hold_cnt, gap_cnt, unexp_cnt, unexp_total;
  int          first_acc_cyc, first_dec_cyc, last_dec_cyc;
  logic [31:0] first_acc_addr, first_dec_pc;
  bit          acc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; dec_cnt = 0; hold_cnt = 0; gap_cnt = 0; unexp_cnt = 0;
    first_acc_cyc = -1; first_dec_cyc = -1; last_dec_cyc = -1;
    first_acc_addr = '0; first_dec_pc = '0;
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic step();
    fetch_pkt_t e;
    mem_req_t   m;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_data(m.addr);
    end
    bus.pc_in = pc_model;
    #1;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    chk("pc_hold", bus.pc_hold, !acc);
    if (bus.flush) chk("no_req_in_flush", bus.imem_req_valid, 1'b0);
    if (acc) begin
      chk("req_addr", bus.imem_req_addr, pc_model);
      m.addr = pc_model; m.due = cyc + mem_lat;
      mem_q.push_back(m);
      e.pc = pc_model; e.instr = mem_data(pc_model);
      exp_q.push_back(e);
      if (first_acc_cyc < 0) begin
        first_acc_cyc  = cyc;
        first_acc_addr = bus.imem_req_addr;
      end
      acc_cnt++;
    end else begin
      hold_cnt++;
    end
    if (bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        unexp_cnt++; unexp_total++;
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", bus.dec_pc, e.pc);
        chk("dec_instr", bus.dec_instr, e.instr);
      end
      if (first_dec_cyc < 0) begin
        first_dec_cyc = cyc;
        first_dec_pc  = bus.dec_pc;
      end else if (cyc != last_dec_cyc + 1) begin
        gap_cnt++;
      end
      last_dec_cyc = cyc;
      dec_cnt++;
    end
    if (bus.flush) begin
      exp_q.delete();
      pc_model = target;
    end else if (acc) begin
      pc_model = pc_model + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    bus.imem_req_ready = 1'b0;
    bus.dec_ready      = 1'b1;
    bus.flush          = 1'b0;
    for (int i = 0; i < max_cyc && (exp_q.size() > 0 || mem_q.size() > 0); i++) step();
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_dec_valid", bus.dec_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef IFB_BYPASS_EN
    lat_exp = 1;
`else
    lat_exp = 2;
`endif
    reset = 1'b1;
    bus.pc_in = '0; bus.flush = 1'b0; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.dec_ready = 1'b1;
    pc_model = '0; target = '0; unexp_total = 0;
    clear_stats();
    @(negedge clk);
    chk("rst_dec_valid", bus.dec_valid, 1'b0);
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_pc_hold", bus.pc_hold, 1'b1);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_dec_instr", bus.dec_instr, 32'h0);
    step(); step();

    // Basic fetch, latency 1, decode always ready
    reset = 1'b0; mem_lat = 1; clear_stats(); c0 = cyc;
    repeat (12) step();
    chk("basic_first_req_cycle", first_acc_cyc - c0, 0);
    chk("basic_first_dec_latency", first_dec_cyc - c0, lat_exp);
    chk("basic_first_dec_pc", first_dec_pc, 32'h0);
    chk("basic_no_gap", gap_cnt, 0);
    chk("basic_no_hold", hold_cnt, 0);
    chk("basic_dec_count", dec_cnt, 12 - lat_exp);
    drain(20);

    // Back-pressure from decode
    clear_stats(); bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b0;
    repeat (10) step();
    chk("bp_accepts", acc_cnt, DEPTH);
    chk("bp_no_dec", dec_cnt, 0);
    chk("bp_req_valid", bus.imem_req_valid, 1'b0);
    chk("bp_pc_hold", bus.pc_hold, 1'b1);
    clear_stats();
    drain(20);
    chk("bp_drain_count", dec_cnt, DEPTH);
    chk("bp_drain_no_gap", gap_cnt, 0);

    // Flush with two requests outstanding, latency 3
    clear_stats(); mem_lat = 3; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1;
    step(); step();
    chk("fl2_setup_accepts", acc_cnt, 2);
    clear_stats();
    bus.flush = 1'b1; target = 32'h1234_5678; c0 = cyc;
    step();
    bus.flush = 1'b0;
    repeat (8) step();
    chk("fl2_refetch_cycle", first_acc_cyc - c0, 3);
    chk("fl2_refetch_addr", first_acc_addr, 32'h1234_5678);
    chk("fl2_first_dec_cycle", first_dec_cyc - c0, 3 + mem_lat + lat_exp - 1);
    chk("fl2_first_dec_pc", first_dec_pc, 32'h1234_5678);
    chk("fl2_no_stale_dec", unexp_cnt, 0);
    drain(30);

    // Flush in the same cycle as the only outstanding response
    clear_stats(); mem_lat = 2; bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    step();
    chk("fl1_setup_accepts", acc_cnt, 1);
    clear_stats();
    bus.flush = 1'b1; target = 32'h0000_0400; bus.imem_req_ready = 1'b1; c0 = cyc;
    step();
    bus.flush = 1'b0;
    repeat (6) step();
    chk("fl1_refetch_cycle", first_acc_cyc - c0, 1);
    chk("fl1_refetch_addr", first_acc_addr, 32'h0000_0400);
    chk("fl1_first_dec_cycle", first_dec_cyc - c0, 1 + mem_lat + lat_exp - 1);
    chk("fl1_first_dec_pc", first_dec_pc, 32'h0000_0400);
    chk("fl1_no_stale_dec", unexp_cnt, 0);
    drain(20);

    // Memory stall
    clear_stats(); mem_lat = 1; bus.dec_ready = 1'b1; bus.imem_req_ready = 1'b0;
    held = pc_model;
    repeat (5) step();
    chk("stall_hold_cycles", hold_cnt, 5);
    chk("stall_req_valid", bus.imem_req_valid, 1'b1);
    chk("stall_pc_hold", bus.pc_hold, 1'b1);
    bus.imem_req_ready = 1'b1; c0 = cyc;
    step();
    chk("stall_first_acc_cycle", first_acc_cyc - c0, 0);
    chk("stall_acc_addr", first_acc_addr, held);
    drain(20);

    // Reset with three instructions queued
    clear_stats(); mem_lat = 1; bus.dec_ready = 1'b0; bus.imem_req_ready = 1'b1;
    repeat (3) step();
    bus.imem_req_ready = 1'b0;
    repeat (3) step();
    chk("mid_setup_accepts", acc_cnt, 3);
    chk("mid_dec_valid_before", bus.dec_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_dec_valid", bus.dec_valid, 1'b0);
    chk("mid_rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("mid_rst_dec_pc", bus.dec_pc, 32'h0);
    exp_q.delete(); mem_q.delete(); pc_model = '0;
    bus.imem_req_ready = 1'b1;
    step(); step();
    reset = 1'b0; clear_stats(); c0 = cyc;
    repeat (8) step();
    chk("post_rst_accepts", acc_cnt, DEPTH);
    chk("post_rst_first_acc_cycle", first_acc_cyc - c0, 0);
    chk("post_rst_first_addr", first_acc_addr, 32'h0);
    clear_stats();
    drain(20);
    chk("post_rst_drain_count", dec_cnt, DEPTH);
    chk("post_rst_first_dec_pc", first_dec_pc, 32'h0);

    chk("unexpected_dec_total", unexp_total, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
